seq_mag_comp: RTL and testbench

Multi-cycle, parametrised magnitude comparator. It compares two WIDTH-bit operands MSB-first, STEP bits per clock, and terminates early on the first differing slice. It supports unsigned and two's-complement signed modes and reports greater/less/equal with a start/busy/done handshake. It is the sequential, arbitrary-width replacement for the combinational 2-bit comparator, for datapaths where a wide single-cycle compare would limit timing.

---
 rtl/seq_mag_comp.sv | 130 +++++++++++++
 tb/tb_seq_mag_comp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_comp
//  Description : Multi-cycle magnitude comparator. Two WIDTH-bit operands are
//                compared MSB-first, STEP bits per clock. The compare stops on
//                the first slice that differs. Unsigned and two's-complement
//                signed modes are supported. Control uses a start/busy/done
//                handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand width in bits (>= 2)
//    STEP       bits examined per cycle; must divide WIDTH evenly
//  Ports
//    clk        clock; all state changes on the rising edge
//    rst        synchronous, active-high reset
//    start      compare request; sampled only while busy = 0
//    is_signed  1 = two's-complement compare; captured with start
//    a, b       operands; captured with start
//    busy       a compare is in progress
//    done       one-cycle pulse; the result is valid from this cycle
//    greater    A > B (held until the next accept or reset)
//    less       A < B (held until the next accept or reset)
//    equal      A == B (held until the next accept or reset)
// ============================================================================
module seq_mag_comp #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int NSLICE = WIDTH / STEP;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COMPARE = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;

  // Operand copies. Each compare cycle shifts them left by STEP bits, so the
  // slice under test always sits at the top of the register. This avoids a
  // variable part-select driven by the slice index.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [STEP-1:0]  w_slice_a;
  logic [STEP-1:0]  w_slice_b;
  logic             w_last;

  assign w_slice_a = r_a[WIDTH-1 -: STEP];
  assign w_slice_b = r_b[WIDTH-1 -: STEP];
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless it is set again below.
      done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            // In signed mode the MSB is inverted. This maps two's-complement
            // values to offset binary, so the plain unsigned slice compare
            // gives the signed ordering.
            r_a     <= {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
            r_b     <= {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
            r_idx   <= '0;
            greater <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (w_slice_a != w_slice_b) begin
            // The first differing slice from the top decides the ordering.
            greater <= (w_slice_a > w_slice_b);
            less    <= (w_slice_a < w_slice_b);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            equal   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_a     <= r_a << STEP;
            r_b     <= r_b << STEP;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mag_comp
//  Description : Directed self-checking bench for seq_mag_comp. It
//                instantiates WIDTH=8 with STEP=2, 8 and 1. Index 0/1/2 of
//                the signal arrays selects the instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mag_comp;

  logic clk;
  logic rst;

  logic       start_s [3];
  logic       sgn_s   [3];
  logic [7:0] a_s     [3];
  logic [7:0] b_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       gt_s    [3];
  logic       lt_s    [3];
  logic       eq_s    [3];

  int checks;
  int failures;

  typedef struct {
    logic       sg;
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] res;   // {greater, less, equal}
    int         lat;
  } vec_t;

  vec_t vecs [3];

  seq_mag_comp #(.WIDTH(8), .STEP(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .is_signed(sgn_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .greater(gt_s[0]), .less(lt_s[0]), .equal(eq_s[0])
  );

  seq_mag_comp #(.WIDTH(8), .STEP(8)) u_dut_s8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .is_signed(sgn_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .greater(gt_s[1]), .less(lt_s[1]), .equal(eq_s[1])
  );

  seq_mag_comp #(.WIDTH(8), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start_s[2]), .is_signed(sgn_s[2]),
    .a(a_s[2]), .b(b_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .greater(gt_s[2]), .less(lt_s[2]), .equal(eq_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int k);
    return {gt_s[k], lt_s[k], eq_s[k]};
  endfunction

  // One compare on instance k. Call this about 1 time unit after a rising
  // edge. With disturb set, start is pulsed again during the first busy
  // cycle with different operands, and the compare must ignore it.
  task automatic run_one(input int k, input string tag, input logic sg,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] exp_res, input int exp_lat,
                         input bit disturb);
    int cyc;
    int bcnt;
    bit seen;
    sgn_s[k] = sg; a_s[k] = va; b_s[k] = vb; start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    check($sformatf("%s_clr", tag), {29'd0, res_of(k)}, 32'd0);
    bcnt = busy_s[k] ? 1 : 0;
    cyc  = 0;
    seen = 1'b0;
    if (disturb) begin
      start_s[k] = 1'b1; sgn_s[k] = ~sg; a_s[k] = ~va; b_s[k] = ~vb;
    end
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      start_s[k] = 1'b0; sgn_s[k] = sg; a_s[k] = va; b_s[k] = vb;
      cyc++;
      if (done_s[k]) seen = 1'b1;
      if (busy_s[k]) bcnt++;
    end
    check($sformatf("%s_lat", tag), seen ? cyc : -1, exp_lat);
    check($sformatf("%s_res", tag), {29'd0, res_of(k)}, {29'd0, exp_res});
    check($sformatf("%s_busy", tag), bcnt, exp_lat);
    @(posedge clk); #1;
    check($sformatf("%s_pulse", tag), {31'd0, done_s[k]}, 32'd0);
    check($sformatf("%s_hold", tag), {29'd0, res_of(k)}, {29'd0, exp_res});
  endtask

  // Holds start high across the three entries of vecs. Each next pair is
  // presented in the cycle in which done is high.
  task automatic run_b2b(input int k, input string tag);
    int cyc;
    int n;
    int guard;
    n = 0; cyc = 0; guard = 0;
    sgn_s[k] = vecs[0].sg; a_s[k] = vecs[0].va; b_s[k] = vecs[0].vb;
    start_s[k] = 1'b1;
    @(posedge clk); #1;   // accept edge of the first pair
    while (n < 3 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      cyc++;
      if (done_s[k]) begin
        check($sformatf("%s_lat%0d", tag, n), cyc, vecs[n].lat);
        check($sformatf("%s_res%0d", tag, n), {29'd0, res_of(k)}, {29'd0, vecs[n].res});
        n++;
        cyc = 0;
        if (n < 3) begin
          sgn_s[k] = vecs[n].sg; a_s[k] = vecs[n].va; b_s[k] = vecs[n].vb;
          @(posedge clk); #1;   // accept edge: busy must be back up
          check($sformatf("%s_acc%0d", tag, n), {31'd0, busy_s[k]}, 32'd1);
        end else begin
          start_s[k] = 1'b0;
        end
      end
    end
    start_s[k] = 1'b0;
    check($sformatf("%s_count", tag), n, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcnt;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; sgn_s[k] = 1'b0; a_s[k] = 8'h00; b_s[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_busy", k), {31'd0, busy_s[k]}, 32'd0);
      check($sformatf("rst%0d_done", k), {31'd0, done_s[k]}, 32'd0);
      check($sformatf("rst%0d_res", k), {29'd0, res_of(k)}, 32'd0);
    end

    // When rst and start are high in the same cycle, rst wins.
    start_s[0] = 1'b1; a_s[0] = 8'h12; b_s[0] = 8'h13;
    @(posedge clk); #1;
    rst = 1'b0; start_s[0] = 1'b0;
    check("rst_start_busy", {31'd0, busy_s[0]}, 32'd0);
    @(posedge clk); #1;
    check("rst_start_busy2", {31'd0, busy_s[0]}, 32'd0);

    // STEP=2 directed vectors.
    run_one(0, "u40_3f", 1'b0, 8'h40, 8'h3F, 3'b100, 1, 1'b0);
    run_one(0, "u12_13", 1'b0, 8'h12, 8'h13, 3'b010, 4, 1'b0);
    run_one(0, "ua5_a5", 1'b0, 8'hA5, 8'hA5, 3'b001, 4, 1'b0);
    run_one(0, "s80_01", 1'b1, 8'h80, 8'h01, 3'b010, 1, 1'b0);
    run_one(0, "u80_01", 1'b0, 8'h80, 8'h01, 3'b100, 1, 1'b0);
    run_one(0, "sff_fe", 1'b1, 8'hFF, 8'hFE, 3'b100, 4, 1'b0);
    run_one(0, "ignore", 1'b0, 8'h12, 8'h13, 3'b010, 4, 1'b1);

    // Reset two cycles into a 4-cycle compare.
    sgn_s[0] = 1'b0; a_s[0] = 8'hA5; b_s[0] = 8'hA5; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy_s[0]}, 32'd0);
    check("abort_res", {29'd0, res_of(0)}, 32'd0);
    dcnt = done_s[0] ? 1 : 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_s[0]) dcnt++;
    end
    check("abort_nodone", dcnt, 0);
    run_one(0, "post_rst", 1'b0, 8'h12, 8'h13, 3'b010, 4, 1'b0);

    // Back-to-back with start held high.
    vecs[0] = '{sg: 1'b0, va: 8'h40, vb: 8'h3F, res: 3'b100, lat: 1};
    vecs[1] = '{sg: 1'b0, va: 8'h12, vb: 8'h13, res: 3'b010, lat: 4};
    vecs[2] = '{sg: 1'b1, va: 8'hFF, vb: 8'hFE, res: 3'b100, lat: 4};
    run_b2b(0, "b2b_s2");

    vecs[0] = '{sg: 1'b0, va: 8'h12, vb: 8'h13, res: 3'b010, lat: 1};
    vecs[1] = '{sg: 1'b1, va: 8'h80, vb: 8'h01, res: 3'b010, lat: 1};
    vecs[2] = '{sg: 1'b0, va: 8'hA5, vb: 8'hA5, res: 3'b001, lat: 1};
    run_b2b(1, "b2b_s8");

    vecs[0] = '{sg: 1'b0, va: 8'h40, vb: 8'h3F, res: 3'b100, lat: 2};
    vecs[1] = '{sg: 1'b1, va: 8'h80, vb: 8'h01, res: 3'b010, lat: 1};
    vecs[2] = '{sg: 1'b0, va: 8'hA5, vb: 8'hA5, res: 3'b001, lat: 8};
    run_b2b(2, "b2b_s1");

    run_one(2, "s1_12_13", 1'b0, 8'h12, 8'h13, 3'b010, 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
